// File: rtl/async_fifo_pkg.sv
// Shared types and constants for the asynchronous FIFO read-side blocks.
package async_fifo_pkg;

    localparam int unsigned FIFO_DATA_W = 8;

    typedef logic [FIFO_DATA_W-1:0] fifo_word_t;

    localparam int unsigned RD_STATS_W = 16;

endpackage

// File: rtl/async_fifo_rd_buf.sv
// Ring buffer behind the FIFO read port: storage, head/tail pointers and occupancy.
// DEPTH must be a power of two so the pointers wrap naturally.
module async_fifo_rd_buf
    import async_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = FIFO_DATA_W,
    parameter int unsigned DEPTH  = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [OCC_W-1:0]  occ
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [OCC_W-1:0]  occ_q;
    logic [OCC_W-1:0]  occ_d;

    // Capture: write at the tail and advance it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '{default: '0};
            tail_q <= '0;
        end else if (wr_en) begin
            mem_q[tail_q] <= wr_data;
            tail_q        <= tail_q + PTR_W'(1);
        end
    end

    // Drain: advance the head on every pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
        end else if (rd_en) begin
            head_q <= head_q + PTR_W'(1);
        end
    end

    // Occupancy next state: simultaneous capture and pop cancel out.
    always_comb begin
        occ_d = occ_q + OCC_W'(wr_en) - OCC_W'(rd_en);
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign rd_data = mem_q[head_q];
    assign occ     = occ_q;

endmodule

// File: rtl/async_fifo_rd_stream.sv
// Read-side consumer of the async FIFO: pops words under a credit check and
// presents them as a valid/ready stream.
// Optional statistics (rd_words, stall) are built when ASYNC_FIFO_RD_STATS_EN is defined.
module async_fifo_rd_stream
    import async_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = FIFO_DATA_W,
    parameter int unsigned DEPTH  = 2,
    localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  rempty,
    input  logic [DATA_W-1:0]     rdata,
    output logic                  rinc,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_W-1:0]     m_data,
    output logic [OCC_W-1:0]      occ
`ifdef ASYNC_FIFO_RD_STATS_EN
    ,
    output logic [RD_STATS_W-1:0] rd_words,
    output logic                  stall
`endif
);

    // One extra bit so occ + inflight never wraps before the compare.
    localparam int unsigned         CRED_W  = OCC_W + 1;
    localparam logic [CRED_W-1:0]   DEPTH_C = CRED_W'(DEPTH);

    logic              inflight_q;
    logic              run_q;
    logic              pop;
    logic [CRED_W-1:0] credit;

    assign m_valid = (occ != '0);
    assign pop     = m_valid && m_ready;

    // Pop request: only when the word can be guaranteed a slot on arrival.
    // run_q keeps rinc low until the first edge after reset release.
    always_comb begin
        credit = {1'b0, occ} + CRED_W'(inflight_q) - CRED_W'(pop);
        rinc   = run_q && !rempty && (credit < DEPTH_C);
    end

    // inflight tracks the FIFO's one-cycle registered read latency.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            inflight_q <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            inflight_q <= rinc;
            run_q      <= 1'b1;
        end
    end

    async_fifo_rd_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_buf (
        .clk     (rclk),
        .rst_n   (rrst_n),
        .wr_en   (inflight_q),
        .wr_data (rdata),
        .rd_en   (pop),
        .rd_data (m_data),
        .occ     (occ)
    );

`ifdef ASYNC_FIFO_RD_STATS_EN
    // Saturating pop counter and registered backpressure flag.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rd_words <= '0;
            stall    <= 1'b0;
        end else begin
            if (pop && (rd_words != '1)) begin
                rd_words <= rd_words + RD_STATS_W'(1);
            end
            stall <= m_valid && !m_ready;
        end
    end
`endif

endmodule

// File: doc/async_fifo_rd_stream.md
# async_fifo_rd_stream

Read-side consumer for the team's 8-bit asynchronous FIFO, running entirely in the read clock domain. It drives `rinc` against `rempty`, absorbs the FIFO's one-cycle registered read latency in a small credit-managed buffer, and presents popped words as a valid/ready stream to downstream logic. It is the counterpart of the write-side producer: the producer fills the FIFO through `winc`/`wdata`/`wfull`, and this block drains it through `rinc`/`rdata`/`rempty`.

## Interface
- `DATA_W`, default 8: FIFO word width and stream data width.
- `DEPTH`, default 2: buffer entries. Must be a power of 2 and at least 2.
- `rclk` input, 1 bit: read clock. This is the block's only clock.
- `rrst_n` input, 1 bit: asynchronous, active-low reset.
- `rempty` input, 1 bit: FIFO empty flag, synchronous to `rclk`.
- `rdata` input, `DATA_W` bits: FIFO read data, valid in the cycle after an accepted `rinc`.
- `rinc` output, 1 bit: FIFO pop request.
- `m_valid` output, 1 bit: stream data valid.
- `m_ready` input, 1 bit: downstream accept.
- `m_data` output, `DATA_W` bits: stream data, the head of the buffer.
- `occ` output, `$clog2(DEPTH+1)` bits: number of buffered words.

## Operation
- **Pop rule:** `rinc` is combinational and equals `!rempty && (occ + inflight - pop) < DEPTH`.
  - `pop = m_valid && m_ready`.
  - `inflight` is a register holding the previous cycle's `rinc`.
- **Capture:** when `inflight` is 1, `rdata` is written at the tail and the tail pointer advances modulo `DEPTH`.
- **Drain:** when `pop` is 1, the head pointer advances modulo `DEPTH`.
- **Output:** `m_data` = buffer[head]. `m_valid` = (`occ` != 0).
- **Occupancy:** `occ` next = `occ` + `inflight` − `pop`.
  - Capture and pop in the same cycle leave `occ` unchanged.
  - With `occ` = 0, a simultaneous capture and pop is impossible because `m_valid` is 0.
- **Stream rule:** `m_data` is held stable while `m_valid && !m_ready`. `m_valid` never drops without a pop.
- **Empty handling:** the credit check guarantees the buffer never overflows, so a capture is never dropped. `rinc` is never asserted while `rempty` is 1.
- **Reset:** `rinc` = 0, `m_valid` = 0, `m_data` = 0, `occ` = 0, `inflight` = 0, and both pointers = 0.
  - Reset asserted mid-operation discards buffered and in-flight words.
  - The FIFO read side shares `rrst_n`, so no stale capture occurs after release.

## Timing
- Latency: `rinc` high in cycle N → `rdata` captured at the end of cycle N+1 → `m_valid` high in cycle N+2.
- Throughput: one word per cycle sustained with `m_ready` held at 1 and `DEPTH` = 2.
- Backpressure: `m_ready` = 0 with `occ` = `DEPTH` − 1 and `inflight` = 1 forces `rinc` = 0 in that cycle.
- After the first registered edge following reset release, `rinc` may assert in the same cycle that `rempty` falls.

## Configuration
- `ASYNC_FIFO_RD_STATS_EN` defined:
  - Adds output `rd_words`, 16 bits, reset 0. It increments on each `pop` and saturates at 0xFFFF.
  - Adds output `stall`, 1 bit, registered. It is 1 for every cycle in which `m_valid && !m_ready`.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

## Structure
- Package `async_fifo_pkg` holds:
  - `FIFO_DATA_W = 8`
  - `typedef logic [FIFO_DATA_W-1:0] fifo_word_t`
  - `RD_STATS_W = 16`
- Sub-module `async_fifo_rd_buf` holds the ring storage, head/tail pointers and `occ`. Its inputs are `wr_en`, `wr_data`, `rd_en`.
- The top level holds the credit logic, the `inflight` register and the optional stats.

## Test plan
- Reset then FIFO preloaded with 0x11, 0x22, 0x33, `m_ready` = 1 → `rinc` high for 3 cycles; `m_data` = 0x11, 0x22, 0x33 on consecutive cycles starting 2 cycles after the first `rinc`; `rempty` = 1 afterwards gives `rinc` = 0 and `m_valid` = 0.
- 4 words 0xA0–0xA3, `m_ready` = 0 → `rinc` pulses exactly 2 times and `occ` = 2; `m_data` holds 0xA0 until `m_ready` = 1; all 4 words arrive in order.
- `m_ready` toggling 1,0,1,0 over 8 words 0x00–0x07 → no loss, no duplication, and `occ` ≤ 2 throughout.
- `rrst_n` asserted with `occ` = 2 and `inflight` = 1 → `m_valid` = 0 and `rinc` = 0 immediately; after release and reloading with 0x5A, only 0x5A is delivered.
- `rempty` held at 1 for 20 cycles → `rinc` stays 0 and `m_valid` stays 0.
- With `ASYNC_FIFO_RD_STATS_EN` defined, 5 pops → `rd_words` = 5; 3 backpressured cycles → `stall` high for 3 cycles.
